// File: rtl/pos_onehot_decoder_if.sv
// Handshake bundle between a position-code producer and a one-hot consumer.
// Latency: none (wires only).
// Backpressure: carried by in_ready / out_ready.
interface pos_onehot_decoder_if #(
  parameter int DEPTH = 4
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_pos;
  logic          in_none;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_onehot;
  logic [3:0]    seen_mask;
  logic          seen_clear;
  logic [LW-1:0] level;

  // Decoder side
  modport slave (
    input  in_valid, in_pos, in_none, out_ready, seen_clear,
    output in_ready, out_valid, out_onehot, seen_mask, level
  );

  // Producer / consumer side
  modport master (
    output in_valid, in_pos, in_none, out_ready, seen_clear,
    input  in_ready, out_valid, out_onehot, seen_mask, level
  );
endinterface

// File: rtl/pos_onehot_decoder.sv
// Buffers {none,pos} codes in a DEPTH-entry FIFO and emits the rebuilt 4-bit one-hot word.
// Latency: 1 cycle from push to head on an empty FIFO; no bypass path.
// Backpressure: in_ready drops when full (registered, ignores same-cycle pop); head holds while out_ready=0.
module pos_onehot_decoder #(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  pos_onehot_decoder_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic       none;
    logic [1:0] pos;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [3:0]    seen_q, seen_d;

  logic          in_ready;
  logic          out_valid;
  logic          push;
  logic          pop;
  entry_t        head;
  logic [3:0]    onehot;

  // Handshake qualifiers and head decode, all from registered state
  always_comb begin
    in_ready  = (level_q != LW'(DEPTH));
    out_valid = (level_q != '0);
    push      = bus.in_valid & in_ready;
    pop       = out_valid & bus.out_ready;
    head      = mem_q[rd_ptr_q];
    onehot    = 4'b0000;
    if (out_valid && !head.none) begin
      onehot = 4'b0001 << head.pos;
    end
  end

  // Next-state for pointers, occupancy and the sticky seen mask
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    seen_d   = seen_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A clear wins over a same-cycle pop, dropping that word from the mask
    if (bus.seen_clear) begin
      seen_d = 4'b0000;
    end else if (pop) begin
      seen_d = seen_q | onehot;
    end
  end

  // Control state; reset discards every queued entry at once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      seen_q   <= 4'b0000;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      seen_q   <= seen_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_t'{none: bus.in_none, pos: bus.in_pos};
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_onehot = onehot;
  assign bus.seen_mask  = seen_q;
  assign bus.level      = level_q;
endmodule
